jpeg_mcu_block_scheduler: RTL

- Sequences 8x8 component blocks from the Y/Cb/Cr line buffers into the single shared DCT/quantize/entropy datapath, one block at a time, in fixed MCU order: Y x Y_PER_MCU, then Cb, then Cr.
- Grants exactly one requester per block.
- Holds off the next grant until the datapath signals completion.
- Counts MCUs against a programmed frame total.
- Sits between the component buffer controllers and the datapath start/done interface.

---
 rtl/jpeg_mcu_block_scheduler_if.sv | 31 +++
 rtl/jpeg_mcu_block_scheduler.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/jpeg_mcu_block_scheduler_if.sv
// Handshake bundle between the MCU block scheduler and its neighbours.
// The master side drives the buffer requests, datapath status and frame control.
// The slave side is the scheduler: grants, datapath start and progress reporting.
interface jpeg_mcu_block_scheduler_if #(
  parameter int MCU_W = 16
);
  logic             start;
  logic             abort;
  logic [MCU_W-1:0] cfg_mcu_total;
  logic [2:0]       req;
  logic [2:0]       gnt;
  logic             dp_ready;
  logic             dp_start;
  logic [1:0]       dp_comp;
  logic             dp_done;
  logic             busy;
  logic             done;
  logic [MCU_W-1:0] mcu_idx;
  logic [2:0]       blk_idx;
  logic             err_spurious;

  modport master (
    output start, abort, cfg_mcu_total, req, dp_ready, dp_done,
    input  gnt, dp_start, dp_comp, busy, done, mcu_idx, blk_idx, err_spurious
  );

  modport slave (
    input  start, abort, cfg_mcu_total, req, dp_ready, dp_done,
    output gnt, dp_start, dp_comp, busy, done, mcu_idx, blk_idx, err_spurious
  );
endinterface

// File: rtl/jpeg_mcu_block_scheduler.sv
// Issues Y..Y, Cb, Cr blocks of each MCU, one at a time, to the shared DCT datapath.
// Latency: grant one cycle after req+dp_ready are sampled; next grant >= 2 cycles after dp_done.
// Backpressure: waits in WAIT for the required component's req and dp_ready; other requests ignored.
module jpeg_mcu_block_scheduler #(
  parameter int Y_PER_MCU = 4,
  parameter int MCU_W     = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  jpeg_mcu_block_scheduler_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_ADVANCE, S_FIN} state_t;

  // Block positions of the two chroma blocks within an MCU.
  localparam logic [2:0] CB_POS = 3'(Y_PER_MCU);
  localparam logic [2:0] CR_POS = 3'(Y_PER_MCU + 1);

  state_t           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic             dp_start_q, dp_start_d;
  logic [1:0]       dp_comp_q, dp_comp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [MCU_W-1:0] mcu_idx_q, mcu_idx_d;
  logic [2:0]       blk_idx_q, blk_idx_d;
  logic             err_q, err_d;
  logic [MCU_W-1:0] total_q, total_d;

  logic [1:0] comp;
  logic       start_ok;
  logic       blk_ok;
  logic       last_blk;

  // Component owed at the current block position; no reordering is ever done.
  assign comp = (blk_idx_q < CB_POS) ? 2'd0 : (blk_idx_q == CB_POS) ? 2'd1 : 2'd2;

  assign start_ok = (state_q == S_IDLE) && bus.start && !bus.abort;
  assign blk_ok   = bus.req[comp] && bus.dp_ready;
  // The block that just finished is the Cr block of the final MCU.
  assign last_blk = (blk_idx_q == CR_POS) && (mcu_idx_q == total_q - MCU_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (start_ok) state_d = (bus.cfg_mcu_total == '0) ? S_FIN : S_WAIT;
    end else if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_WAIT:    if (blk_ok) state_d = S_RUN;
        S_RUN:     if (bus.dp_done) state_d = S_ADVANCE;
        S_ADVANCE: state_d = last_blk ? S_FIN : S_WAIT;
        S_FIN:     state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    gnt_d      = 3'b000;
    dp_start_d = 1'b0;
    done_d     = 1'b0;
    dp_comp_d  = dp_comp_q;
    busy_d     = busy_q;
    mcu_idx_d  = mcu_idx_q;
    blk_idx_d  = blk_idx_q;
    total_d    = total_q;
    // A completion is only expected while a block is in flight.
    err_d      = err_q | (bus.dp_done && (state_q != S_RUN));
    if (state_q == S_IDLE) begin
      if (start_ok) begin
        total_d   = bus.cfg_mcu_total;
        mcu_idx_d = '0;
        blk_idx_d = 3'd0;
        err_d     = 1'b0;
        busy_d    = 1'b1;
      end
    end else if (bus.abort) begin
      // Counters are left untouched so software can see where the frame stopped.
      busy_d = 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (blk_ok) begin
            gnt_d      = 3'b001 << comp;
            dp_start_d = 1'b1;
            dp_comp_d  = comp;
          end
        end
        S_ADVANCE: begin
          if (blk_idx_q < CR_POS) begin
            blk_idx_d = blk_idx_q + 3'd1;
          end else begin
            blk_idx_d = 3'd0;
            mcu_idx_d = mcu_idx_q + MCU_W'(1);
          end
        end
        S_FIN: begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= 3'b000;
      dp_start_q <= 1'b0;
      dp_comp_q  <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mcu_idx_q  <= '0;
      blk_idx_q  <= 3'd0;
      err_q      <= 1'b0;
      total_q    <= '0;
    end else begin
      gnt_q      <= gnt_d;
      dp_start_q <= dp_start_d;
      dp_comp_q  <= dp_comp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mcu_idx_q  <= mcu_idx_d;
      blk_idx_q  <= blk_idx_d;
      err_q      <= err_d;
      total_q    <= total_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.dp_start     = dp_start_q;
  assign bus.dp_comp      = dp_comp_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mcu_idx      = mcu_idx_q;
  assign bus.blk_idx      = blk_idx_q;
  assign bus.err_spurious = err_q;

endmodule
